// File: rtl/alu_control_mdu.sv
// ALU control decoder with an iterative RV32M multiply/divide unit.
//
// Ports:
//   clk, rst            - single clock, synchronous active-high reset
//   start_i             - execute-stage instruction valid
//   is_immediate_i      - OP-IMM instruction
//   ALU_CO_i            - main-decoder class (00 ld/st, 01 branch, 10 ALU, 11 other)
//   FUNC7_i, FUNC3_i    - instruction function fields
//   rs1_i, rs2_i        - source operands
//   ALU_OP_o            - combinational ALU operation code
//   use_mdu_o           - combinational: fields decode as an M-extension op
//   busy_o              - stall request while an MDU op is accepted or running
//   done_o              - one-cycle pulse, mdu_result_o valid
//   mdu_result_o        - multiply/divide result, held until the next completion
module alu_control_mdu #(
  parameter int XLEN     = 32,
  parameter int ENABLE_M = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            is_immediate_i,
  input  logic [1:0]      ALU_CO_i,
  input  logic [6:0]      FUNC7_i,
  input  logic [2:0]      FUNC3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic [3:0]      ALU_OP_o,
  output logic            use_mdu_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] mdu_result_o
);

  localparam int CW = $clog2(XLEN);

  localparam logic [3:0] OP_AND = 4'b0000, OP_OR   = 4'b0001, OP_SUM = 4'b0010,
                         OP_EQ  = 4'b0011, OP_SLL  = 4'b0100, OP_SRL = 4'b0101,
                         OP_SRA = 4'b0111, OP_XOR  = 4'b1000, OP_SUB = 4'b1010,
                         OP_GE  = 4'b1100, OP_GEU  = 4'b1101, OP_SLT = 4'b1110,
                         OP_SLTU = 4'b1111;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t              state_q, state_d;
  logic [1:0]          f3_q;
  logic [XLEN-1:0]     rs1_q, a_q;
  logic [2*XLEN-1:0]   acc_q;
  logic [CW-1:0]       cnt_q;
  logic                neg_q, negr_q, dz_q, ovf_q;
  logic [XLEN-1:0]     res_q;

  // ---------------- decode ----------------
  always_comb begin
    use_mdu_o = (ENABLE_M != 0) && (ALU_CO_i == 2'b10) && !is_immediate_i &&
                (FUNC7_i == 7'b0000001);
    ALU_OP_o  = OP_SUM;
    if (!use_mdu_o) begin
      case (ALU_CO_i)
        2'b01: begin
          case (FUNC3_i)
            3'b001:  ALU_OP_o = OP_EQ;
            3'b100:  ALU_OP_o = OP_GE;
            3'b101:  ALU_OP_o = OP_SLT;
            3'b110:  ALU_OP_o = OP_GEU;
            3'b111:  ALU_OP_o = OP_SLTU;
            default: ALU_OP_o = OP_SUB;
          endcase
        end
        2'b10: begin
          case (FUNC3_i)
            3'b000:  ALU_OP_o = (!is_immediate_i && FUNC7_i[5]) ? OP_SUB : OP_SUM;
            3'b001:  ALU_OP_o = OP_SLL;
            3'b010:  ALU_OP_o = OP_SLT;
            3'b011:  ALU_OP_o = OP_SLTU;
            3'b100:  ALU_OP_o = OP_XOR;
            3'b101:  ALU_OP_o = FUNC7_i[5] ? OP_SRA : OP_SRL;
            3'b110:  ALU_OP_o = OP_OR;
            default: ALU_OP_o = OP_AND;
          endcase
        end
        default: ALU_OP_o = OP_SUM;
      endcase
    end
  end

  // ---------------- operand preparation ----------------
  logic            s1, s2, n1, n2;
  logic [XLEN-1:0] m1, m2;

  always_comb begin
    // MUL is treated as signed; its low product half is signedness-independent.
    s1 = FUNC3_i[2] ? ~FUNC3_i[0] : (FUNC3_i[1:0] != 2'b11);
    s2 = FUNC3_i[2] ? ~FUNC3_i[0] : ~FUNC3_i[1];
    n1 = s1 & rs1_i[XLEN-1];
    n2 = s2 & rs2_i[XLEN-1];
    m1 = n1 ? -rs1_i : rs1_i;
    m2 = n2 ? -rs2_i : rs2_i;
  end

  // ---------------- iteration datapath ----------------
  // acc_q holds {high, low}: product/multiplier for MUL, remainder/quotient for DIV.
  logic [XLEN:0]     mul_sum, div_part;
  logic [XLEN-1:0]   div_sub, div_rem;
  logic [2*XLEN-1:0] mul_next, mul_fin, div_next;
  logic              div_ge, cnt_last;
  logic [XLEN-1:0]   mul_res, quo_res, rem_res, div_res, fast_res;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    mul_fin  = neg_q ? -mul_next : mul_next;
    mul_res  = (f3_q == 2'b00) ? mul_fin[XLEN-1:0] : mul_fin[2*XLEN-1:XLEN];

    div_part = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_ge   = (div_part >= {1'b0, a_q});
    // Difference is below the divisor whenever it is kept, so XLEN bits suffice.
    div_sub  = div_part[XLEN-1:0] - a_q;
    div_rem  = div_ge ? div_sub : div_part[XLEN-1:0];
    div_next = {div_rem, acc_q[XLEN-2:0], div_ge};
    quo_res  = neg_q  ? -div_next[XLEN-1:0]      : div_next[XLEN-1:0];
    rem_res  = negr_q ? -div_next[2*XLEN-1:XLEN] : div_next[2*XLEN-1:XLEN];
    div_res  = f3_q[1] ? rem_res : quo_res;

    fast_res = dz_q ? (f3_q[1] ? rs1_q : '1) : (f3_q[1] ? '0 : rs1_q);
    cnt_last = (cnt_q == CW'(XLEN-1));
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_i && use_mdu_o) state_d = FUNC3_i[2] ? DIV : MUL;
      MUL:  if (cnt_last) state_d = DONE;
      DIV:  if (dz_q || ovf_q || cnt_last) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o = 1'b0;
    done_o = 1'b0;
    case (state_q)
      IDLE:    busy_o = start_i && use_mdu_o;
      MUL,
      DIV:     busy_o = 1'b1;
      default: done_o = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f3_q   <= '0;
      rs1_q  <= '0;
      a_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      neg_q  <= 1'b0;
      negr_q <= 1'b0;
      dz_q   <= 1'b0;
      ovf_q  <= 1'b0;
      res_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i && use_mdu_o) begin
            f3_q   <= FUNC3_i[1:0];
            rs1_q  <= rs1_i;
            a_q    <= FUNC3_i[2] ? m2 : m1;
            acc_q  <= {{XLEN{1'b0}}, (FUNC3_i[2] ? m1 : m2)};
            cnt_q  <= '0;
            neg_q  <= n1 ^ n2;
            negr_q <= n1;
            dz_q   <= (rs2_i == '0);
            ovf_q  <= FUNC3_i[2] & ~FUNC3_i[0] & (rs2_i == '1) &
                      (rs1_i == {1'b1, {(XLEN-1){1'b0}}});
          end
        end
        MUL: begin
          acc_q <= mul_next;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_last) res_q <= mul_res;
        end
        DIV: begin
          if (dz_q || ovf_q) begin
            res_q <= fast_res;
          end else begin
            acc_q <= div_next;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_last) res_q <= div_res;
          end
        end
        default: ;
      endcase
    end
  end

  assign mdu_result_o = res_q;

endmodule

// File: tb/tb_alu_control_mdu.sv
// Directed bench for alu_control_mdu: decode table, multiply/divide vectors
// with latency, DONE behaviour, reset abort and the ENABLE_M=0 variant.
module tb_alu_control_mdu;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start_i = 1'b0;
  logic            is_immediate_i = 1'b0;
  logic [1:0]      ALU_CO_i = 2'b00;
  logic [6:0]      FUNC7_i = 7'd0;
  logic [2:0]      FUNC3_i = 3'd0;
  logic [XLEN-1:0] rs1_i = '0;
  logic [XLEN-1:0] rs2_i = '0;

  logic [3:0]      alu_op, alu_op0;
  logic            use_mdu, use_mdu0, busy, busy0, done, done0;
  logic [XLEN-1:0] result, result0;

  alu_control_mdu #(.XLEN(XLEN), .ENABLE_M(1)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .is_immediate_i(is_immediate_i),
    .ALU_CO_i(ALU_CO_i), .FUNC7_i(FUNC7_i), .FUNC3_i(FUNC3_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .ALU_OP_o(alu_op), .use_mdu_o(use_mdu),
    .busy_o(busy), .done_o(done), .mdu_result_o(result)
  );

  alu_control_mdu #(.XLEN(XLEN), .ENABLE_M(0)) dut0 (
    .clk(clk), .rst(rst), .start_i(start_i), .is_immediate_i(is_immediate_i),
    .ALU_CO_i(ALU_CO_i), .FUNC7_i(FUNC7_i), .FUNC3_i(FUNC3_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .ALU_OP_o(alu_op0), .use_mdu_o(use_mdu0),
    .busy_o(busy0), .done_o(done0), .mdu_result_o(result0)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  logic [XLEN-1:0] last_exp = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] co;
    logic       imm;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [3:0] op;
    logic [3:0] op0;
    logic       mdu;
  } dec_t;

  typedef struct {
    logic [2:0]      f3;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] exp;
    int              lat;
  } mdu_t;

  dec_t dec[23];
  mdu_t mv[18];

  task automatic run_op(input logic [2:0] f3, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp,
                        input int lat);
    int cyc;
    int bad;
    bit seen;
    @(negedge clk);
    start_i = 1'b1; ALU_CO_i = 2'b10; is_immediate_i = 1'b0;
    FUNC7_i = 7'b0000001; FUNC3_i = f3; rs1_i = a; rs2_i = b;
    #1;
    check("busy at accept", busy, 1);
    check("use_mdu at accept", use_mdu, 1);
    check("alu_op SUM for mdu", alu_op, 4'b0010);
    check("no-M busy", busy0, 0);
    check("no-M use_mdu", use_mdu0, 0);
    seen = 0; cyc = 0; bad = 0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start_i = 1'b0; rs1_i = ~a; rs2_i = ~b; FUNC3_i = ~f3;
      end
      #1;
      if (done === 1'b1) begin
        seen = 1; cyc = c;
      end else if (c < lat) begin
        if (busy !== 1'b1) bad++;
        if (result !== last_exp) bad++;
      end
    end
    check("busy/hold while running", bad, 0);
    check("done cycle", cyc, lat);
    check("result", result, exp);
    check("busy in DONE", busy, 0);
    last_exp = exp;
    // Offer a new MUL while in DONE; it must not be taken.
    start_i = 1'b1; FUNC3_i = 3'b000;
    @(negedge clk);
    start_i = 1'b0;
    #1;
    check("done one cycle", done, 0);
    check("start in DONE ignored", busy, 0);
    check("result held", result, exp);
  endtask

  initial begin
    dec[0]  = '{2'b00, 1'b0, 7'h00, 3'b101, 4'b0010, 4'b0010, 1'b0};
    dec[1]  = '{2'b11, 1'b0, 7'h20, 3'b111, 4'b0010, 4'b0010, 1'b0};
    dec[2]  = '{2'b01, 1'b0, 7'h00, 3'b000, 4'b1010, 4'b1010, 1'b0};
    dec[3]  = '{2'b01, 1'b0, 7'h00, 3'b001, 4'b0011, 4'b0011, 1'b0};
    dec[4]  = '{2'b01, 1'b0, 7'h00, 3'b100, 4'b1100, 4'b1100, 1'b0};
    dec[5]  = '{2'b01, 1'b0, 7'h00, 3'b101, 4'b1110, 4'b1110, 1'b0};
    dec[6]  = '{2'b01, 1'b0, 7'h00, 3'b110, 4'b1101, 4'b1101, 1'b0};
    dec[7]  = '{2'b01, 1'b0, 7'h00, 3'b111, 4'b1111, 4'b1111, 1'b0};
    dec[8]  = '{2'b01, 1'b0, 7'h00, 3'b010, 4'b1010, 4'b1010, 1'b0};
    dec[9]  = '{2'b10, 1'b0, 7'h20, 3'b000, 4'b1010, 4'b1010, 1'b0};
    dec[10] = '{2'b10, 1'b1, 7'h20, 3'b000, 4'b0010, 4'b0010, 1'b0};
    dec[11] = '{2'b10, 1'b0, 7'h00, 3'b000, 4'b0010, 4'b0010, 1'b0};
    dec[12] = '{2'b10, 1'b0, 7'h00, 3'b001, 4'b0100, 4'b0100, 1'b0};
    dec[13] = '{2'b10, 1'b0, 7'h00, 3'b010, 4'b1110, 4'b1110, 1'b0};
    dec[14] = '{2'b10, 1'b0, 7'h00, 3'b011, 4'b1111, 4'b1111, 1'b0};
    dec[15] = '{2'b10, 1'b0, 7'h00, 3'b100, 4'b1000, 4'b1000, 1'b0};
    dec[16] = '{2'b10, 1'b0, 7'h20, 3'b101, 4'b0111, 4'b0111, 1'b0};
    dec[17] = '{2'b10, 1'b0, 7'h00, 3'b101, 4'b0101, 4'b0101, 1'b0};
    dec[18] = '{2'b10, 1'b0, 7'h00, 3'b110, 4'b0001, 4'b0001, 1'b0};
    dec[19] = '{2'b10, 1'b0, 7'h00, 3'b111, 4'b0000, 4'b0000, 1'b0};
    dec[20] = '{2'b10, 1'b0, 7'h01, 3'b011, 4'b0010, 4'b1111, 1'b1};
    dec[21] = '{2'b10, 1'b1, 7'h01, 3'b011, 4'b1111, 4'b1111, 1'b0};
    dec[22] = '{2'b01, 1'b0, 7'h01, 3'b100, 4'b1100, 4'b1100, 1'b0};

    mv[0]  = '{3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 33};
    mv[1]  = '{3'b000, 32'h12345678, 32'h00000010, 32'h23456780, 33};
    mv[2]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
    mv[3]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33};
    mv[4]  = '{3'b010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 33};
    mv[5]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33};
    mv[6]  = '{3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33};
    mv[7]  = '{3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33};
    mv[8]  = '{3'b101, 32'h00000064, 32'h00000007, 32'h0000000E, 33};
    mv[9]  = '{3'b111, 32'h00000064, 32'h00000007, 32'h00000002, 33};
    mv[10] = '{3'b110, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 33};
    mv[11] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2};
    mv[12] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 2};
    mv[13] = '{3'b101, 32'h00000064, 32'h00000000, 32'hFFFFFFFF, 2};
    mv[14] = '{3'b111, 32'h00000064, 32'h00000000, 32'h00000064, 2};
    mv[15] = '{3'b100, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFF, 2};
    mv[16] = '{3'b110, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 2};
    mv[17] = '{3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33};

    // Reset state; decode must follow inputs while reset is held.
    ALU_CO_i = 2'b01; FUNC3_i = 3'b100;
    repeat (2) @(negedge clk);
    #1;
    check("reset done", done, 0);
    check("reset result", result, 0);
    check("reset busy", busy, 0);
    check("decode during reset", alu_op, 4'b1100);
    rst = 1'b0;

    foreach (dec[i]) begin
      @(negedge clk);
      ALU_CO_i = dec[i].co; is_immediate_i = dec[i].imm;
      FUNC7_i = dec[i].f7; FUNC3_i = dec[i].f3;
      #1;
      check($sformatf("dec[%0d] alu_op", i), alu_op, dec[i].op);
      check($sformatf("dec[%0d] use_mdu", i), use_mdu, dec[i].mdu);
      check($sformatf("dec[%0d] no-M alu_op", i), alu_op0, dec[i].op0);
      check($sformatf("dec[%0d] no-M use_mdu", i), use_mdu0, 0);
      check($sformatf("dec[%0d] busy", i), busy, 0);
    end

    foreach (mv[i]) run_op(mv[i].f3, mv[i].a, mv[i].b, mv[i].exp, mv[i].lat);

    // Reset in cycle 10 of a running DIVU aborts it silently.
    begin
      int pulses;
      @(negedge clk);
      start_i = 1'b1; ALU_CO_i = 2'b10; is_immediate_i = 1'b0;
      FUNC7_i = 7'b0000001; FUNC3_i = 3'b101; rs1_i = 32'd1000; rs2_i = 32'd3;
      for (int c = 1; c <= 10; c++) begin
        @(negedge clk);
        start_i = 1'b0;
        if (c == 10) rst = 1'b1;
      end
      #1;
      check("busy in reset cycle", busy, 1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("busy after abort", busy, 0);
      check("result after abort", result, 0);
      pulses = 0;
      for (int c = 0; c < 40; c++) begin
        if (done === 1'b1) pulses++;
        @(negedge clk);
        #1;
      end
      check("no done after abort", pulses, 0);
      last_exp = '0;
    end

    run_op(3'b101, 32'd1000, 32'd3, 32'd333, 33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
